// File: rtl/nios_sys_pwm_pio_pkg.sv
// Shared constants for the Nios PWM-capable output PIO: register map and mode encoding.
package nios_sys_pwm_pio_pkg;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PRESCALE_W = 16;
    localparam int unsigned DUTY_IDX_W = 5;

    localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MODE       = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_DUTY_INDEX = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_DUTY_DATA  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET     = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR   = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_STATUS     = 3'd7;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_PWM    = 1'b1
    } pwm_mode_e;

endpackage

// File: rtl/nios_sys_pwm_pio_if.sv
// Avalon-MM slave bus bundle for the PWM PIO register file.
interface nios_sys_pwm_pio_if;
    import nios_sys_pwm_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_sys_pio_pwm_timebase.sv
// Shared PWM timebase: prescaled tick generator plus free-running phase counter.
module nios_sys_pio_pwm_timebase
    import nios_sys_pwm_pio_pkg::*;
#(
    parameter int unsigned             PWM_BITS         = 8,
    parameter logic [PRESCALE_W-1:0]   PRESCALE_DEFAULT = 16'd49
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  reload,
    output logic                  tick,
    output logic [PWM_BITS-1:0]   phase,
    output logic                  wrap
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PWM_BITS-1:0]   phase_q;

    // A reload strobe suppresses the tick that would otherwise fire this cycle.
    assign tick  = (cnt_q == '0) && !reload;
    assign wrap  = tick && (phase_q == '1);
    assign phase = phase_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= PRESCALE_DEFAULT;
            phase_q <= '0;
        end else begin
            if (reload || (cnt_q == '0)) begin
                cnt_q <= prescale;
            end else begin
                cnt_q <= cnt_q - PRESCALE_W'(1);
            end
            if (tick) begin
                phase_q <= phase_q + PWM_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/nios_sys_pwm_pio.sv
// Avalon-MM output PIO with per-channel static/PWM mode, glitch-free duty updates
// and atomic set/clear access to the DATA register.
module nios_sys_pwm_pio
    import nios_sys_pwm_pio_pkg::*;
#(
    parameter int unsigned           WIDTH            = 8,
    parameter int unsigned           PWM_BITS         = 8,
    parameter logic [PRESCALE_W-1:0] PRESCALE_DEFAULT = 16'd49,
    parameter logic [DATA_W-1:0]     RESET_VALUE      = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nios_sys_pwm_pio_if.slave    bus,
    output logic [WIDTH-1:0]     out_port
);

    logic [WIDTH-1:0]      data_q;
    logic [WIDTH-1:0]      mode_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [DUTY_IDX_W-1:0] duty_index_q;
    logic [PWM_BITS-1:0]   pend_q [WIDTH];
    logic [PWM_BITS-1:0]   act_q  [WIDTH];

    logic                  wr_c;
    logic                  reload_c;
    logic                  duty_we_c;
    logic [PRESCALE_W-1:0] prescale_c;
    logic [PWM_BITS-1:0]   duty_rd_c;
    logic [WIDTH-1:0]      out_c;
    logic [PWM_BITS-1:0]   phase;
    logic                  wrap;
    logic                  unused_tick;
    logic                  unused_wd;

    assign wr_c       = bus.chipselect && !bus.write_n;
    assign reload_c   = wr_c && (bus.address == ADDR_PRESCALE);
    assign duty_we_c  = wr_c && (bus.address == ADDR_DUTY_DATA);
    // The counter reloads with the value being written, not the stale register.
    assign prescale_c = reload_c ? bus.writedata[PRESCALE_W-1:0] : prescale_q;
    assign unused_wd  = ^bus.writedata;

    nios_sys_pio_pwm_timebase #(
        .PWM_BITS         (PWM_BITS),
        .PRESCALE_DEFAULT (PRESCALE_DEFAULT)
    ) u_timebase (
        .clk      (clk),
        .reset_n  (reset_n),
        .prescale (prescale_c),
        .reload   (reload_c),
        .tick     (unused_tick),
        .phase    (phase),
        .wrap     (wrap)
    );

    // Control registers; OUTSET/OUTCLEAR operate on DATA as it was before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= WIDTH'(RESET_VALUE);
            mode_q       <= '0;
            prescale_q   <= PRESCALE_DEFAULT;
            duty_index_q <= '0;
        end else if (wr_c) begin
            case (bus.address)
                ADDR_DATA:       data_q       <= bus.writedata[WIDTH-1:0];
                ADDR_MODE:       mode_q       <= bus.writedata[WIDTH-1:0];
                ADDR_PRESCALE:   prescale_q   <= bus.writedata[PRESCALE_W-1:0];
                ADDR_DUTY_INDEX: duty_index_q <= bus.writedata[DUTY_IDX_W-1:0];
                ADDR_OUTSET:     data_q       <= data_q | bus.writedata[WIDTH-1:0];
                ADDR_OUTCLEAR:   data_q       <= data_q & ~bus.writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Pending duties are software-visible; active duties only move on phase wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (duty_we_c && (duty_index_q == DUTY_IDX_W'(i))) begin
                    pend_q[i] <= bus.writedata[PWM_BITS-1:0];
                end
                if (wrap) begin
                    act_q[i] <= pend_q[i];
                end
            end
        end
    end

    // Out-of-range DUTY_INDEX matches no channel and reads back as zero.
    always_comb begin
        duty_rd_c = '0;
        out_c     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (duty_index_q == DUTY_IDX_W'(i)) begin
                duty_rd_c = pend_q[i];
            end
            if (pwm_mode_e'(mode_q[i]) == MODE_PWM) begin
                out_c[i] = data_q[i] & (phase < act_q[i]);
            end else begin
                out_c[i] = data_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= WIDTH'(RESET_VALUE);
        end else begin
            out_port <= out_c;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:       bus.readdata = DATA_W'(data_q);
            ADDR_MODE:       bus.readdata = DATA_W'(mode_q);
            ADDR_PRESCALE:   bus.readdata = DATA_W'(prescale_q);
            ADDR_DUTY_INDEX: bus.readdata = DATA_W'(duty_index_q);
            ADDR_DUTY_DATA:  bus.readdata = DATA_W'(duty_rd_c);
            ADDR_STATUS:     bus.readdata = DATA_W'(out_port);
            default:         bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_sys_pwm_pio.sv
// Scoreboard bench for nios_sys_pwm_pio: register access, atomic set/clear,
// PWM waveform shape, glitch-free duty change and asynchronous reset.
module tb_nios_sys_pwm_pio;
    import nios_sys_pwm_pio_pkg::*;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned PWM_BITS = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] out_port;
    int               cyc = 0;

    nios_sys_pwm_pio_if bus ();

    nios_sys_pwm_pio #(
        .WIDTH            (WIDTH),
        .PWM_BITS         (PWM_BITS),
        .PRESCALE_DEFAULT (16'd49),
        .RESET_VALUE      (32'hA5)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    string       exp_tag [$];
    logic [31:0] exp_val [$];
    bit          samp [512];
    logic [31:0] rd;
    int          t0;
    int          n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_tag.push_back(tag);
        exp_val.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        if (exp_tag.size() == 0) begin
            check("sb_underflow", 32'(exp_tag.size()), 32'd1);
        end else begin
            check(exp_tag.pop_front(), obs, exp_val.pop_front());
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1 d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic read_expect(input string tag, input logic [2:0] a, input logic [31:0] v);
        logic [31:0] d;
        expect_val(tag, v);
        bus_read(a, d);
        observe(d);
    endtask

    // Waits for a low-to-high transition of channel 0, bounded.
    task automatic wait_rise(input string tag, input int bound);
        int  k = 0;
        bit  seen_low = 1'b0;
        bit  found = 1'b0;
        expect_val(tag, 32'd1);
        while (k < bound && !found) begin
            @(negedge clk);
            k++;
            if (!out_port[0]) seen_low = 1'b1;
            else if (seen_low) found = 1'b1;
        end
        observe(32'(found));
    endtask

    task automatic capture(input int len);
        samp[0] = out_port[0];
        for (int k = 1; k < len; k++) begin
            @(negedge clk);
            samp[k] = out_port[0];
        end
    endtask

    function automatic int count_high(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k < hi; k++) c += int'(samp[k]);
        return c;
    endfunction

    function automatic int first_zero(input int len);
        for (int k = 0; k < len; k++) if (!samp[k]) return k;
        return -1;
    endfunction

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        expect_val("rst_out", 32'hA5);
        observe(32'(out_port));
        reset_n = 1'b1;
        expect_val("rst_phase", 32'd0);
        observe(32'(dut.u_timebase.phase));
        read_expect("rst_status",   ADDR_STATUS,   32'hA5);
        read_expect("rst_prescale", ADDR_PRESCALE, 32'd49);
        read_expect("rst_data",     ADDR_DATA,     32'hA5);
        read_expect("rst_mode",     ADDR_MODE,     32'd0);

        // Atomic set/clear
        bus_write(ADDR_DATA,     32'h0F);
        bus_write(ADDR_OUTSET,   32'h30);
        bus_write(ADDR_OUTCLEAR, 32'h03);
        expect_val("setclr_out_prev", 32'h3F);
        observe(32'(out_port));
        @(negedge clk);
        expect_val("setclr_out", 32'h3C);
        observe(32'(out_port));
        read_expect("setclr_data",  ADDR_DATA,     32'h3C);
        read_expect("outset_rd0",   ADDR_OUTSET,   32'd0);
        read_expect("outclear_rd0", ADDR_OUTCLEAR, 32'd0);

        // PWM 64/256 with a tick every cycle
        bus_write(ADDR_DATA,       32'h01);
        bus_write(ADDR_DUTY_INDEX, 32'd0);
        bus_write(ADDR_DUTY_DATA,  32'd64);
        read_expect("duty_rb64", ADDR_DUTY_DATA, 32'd64);
        bus_write(ADDR_MODE,       32'h01);
        bus_write(ADDR_PRESCALE,   32'd0);
        wait_rise("pwm64_rise", 600);
        expect_val("pwm64_high_p1", 32'd64);
        expect_val("pwm64_high_p2", 32'd64);
        expect_val("pwm64_fall",    32'd64);
        expect_val("pwm64_period",  32'd1);
        capture(512);
        observe(32'(count_high(0, 256)));
        observe(32'(count_high(256, 512)));
        observe(32'(first_zero(512)));
        observe(32'({samp[255], samp[256]} == 2'b01));

        // Mid-period duty change must not disturb the running period
        wait_rise("dchg_start", 600);
        t0 = cyc;
        repeat (100) @(negedge clk);
        bus_write(ADDR_DUTY_DATA, 32'd192);
        read_expect("duty_rb192", ADDR_DUTY_DATA, 32'd192);
        wait_rise("dchg_rise", 600);
        expect_val("dchg_period", 32'd256);
        observe(32'(cyc - t0));
        expect_val("pwm192_high", 32'd192);
        expect_val("pwm192_fall", 32'd192);
        expect_val("pwm192_next", 32'd1);
        capture(257);
        observe(32'(count_high(0, 256)));
        observe(32'(first_zero(257)));
        observe(32'(samp[256]));

        // Out-of-range DUTY_INDEX is inert
        bus_write(ADDR_DUTY_INDEX, 32'd12);
        bus_write(ADDR_DUTY_DATA,  32'hFF);
        read_expect("oor_duty_rd", ADDR_DUTY_DATA,  32'd0);
        read_expect("oor_idx_rd",  ADDR_DUTY_INDEX, 32'd12);
        bus_write(ADDR_DUTY_INDEX, 32'd4);
        read_expect("oor_ch4",     ADDR_DUTY_DATA,  32'd0);
        bus_write(ADDR_DUTY_INDEX, 32'd0);
        read_expect("oor_ch0",     ADDR_DUTY_DATA,  32'd192);

        // Duty extremes
        bus_write(ADDR_DUTY_DATA, 32'd0);
        repeat (260) @(negedge clk);
        expect_val("duty0_high", 32'd0);
        capture(256);
        observe(32'(count_high(0, 256)));
        bus_write(ADDR_DUTY_DATA, 32'd255);
        repeat (260) @(negedge clk);
        expect_val("duty255_high", 32'd255);
        capture(256);
        observe(32'(count_high(0, 256)));

        // Asynchronous reset mid-period
        bus_write(ADDR_PRESCALE, 32'd3);
        bus_write(ADDR_DATA,     32'hFF);
        repeat (37) @(negedge clk);
        expect_val("arst_pre_out", 32'hFE);
        observe(32'(out_port & 8'hFE));
        #2 reset_n = 1'b0;
        #1;
        expect_val("arst_out", 32'hA5);
        observe(32'(out_port));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (n < 200 && dut.u_timebase.phase != PWM_BITS'(1)) begin
            @(negedge clk);
            n++;
        end
        expect_val("arst_first_tick", 32'd50);
        observe(32'(n));
        read_expect("arst_duty",     ADDR_DUTY_DATA, 32'd0);
        read_expect("arst_prescale", ADDR_PRESCALE,  32'd49);
        read_expect("arst_status",   ADDR_STATUS,    32'hA5);

        check("sb_empty", 32'(exp_tag.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
